// File: rtl/lfsr_frame_gen.sv
// Galois LFSR frame generator: seed load, counted run, ready/valid LSB-first serial output.
// Optional build macro LFSR_DEBRUIJN_EN inserts the all-zeros state (de Bruijn sequence).
module lfsr_frame_gen #(
   parameter int              WIDTH      = 8,
   parameter logic [WIDTH-1:0] TAPS      = 8'h1C,
   parameter int              CNT_W      = 16,
   parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             start,
   input  logic [CNT_W-1:0] step_cnt,
   input  logic             out_ready,
   output logic             out_bit,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lfsr_q
);

   localparam int BW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, SHIFT} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [BW-1:0]    bitcnt;
   logic [WIDTH-1:0] snap;
   logic [WIDTH-1:0] lfsr_nxt;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
      logic             fb;
      logic [WIDTH-1:0] nxt;
`ifdef LFSR_DEBRUIJN_EN
      fb = v[WIDTH-1] ^ ~|v[WIDTH-2:0];
`else
      fb = v[WIDTH-1];
`endif
      nxt[0] = fb;
      for (int i = 1; i < WIDTH; i++)
         nxt[i] = v[i-1] ^ (TAPS[i] & fb);
      return nxt;
   endfunction

   // Plain Galois feedback locks up at zero, so a zero seed is replaced by 1.
   function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
`ifdef LFSR_DEBRUIJN_EN
      return s;
`else
      return (s == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : s;
`endif
   endfunction

   assign lfsr_nxt = lfsr_step(lfsr_q);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         lfsr_q    <= RESET_SEED;
         cnt       <= '0;
         bitcnt    <= '0;
         snap      <= '0;
         out_bit   <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  lfsr_q <= seed_fix(seed);
               end else if (start) begin
                  bitcnt <= '0;
                  if (step_cnt == '0) begin
                     state     <= SHIFT;
                     snap      <= lfsr_q;
                     out_bit   <= lfsr_q[0];
                     out_valid <= 1'b1;
                  end else begin
                     state <= RUN;
                     cnt   <= step_cnt;
                  end
               end
            end
            RUN: begin
               lfsr_q <= lfsr_nxt;
               cnt    <= cnt - 1'b1;
               // Snapshot the post-step value so the first bit is ready right after the last step.
               if (cnt == CNT_W'(1)) begin
                  state     <= SHIFT;
                  snap      <= lfsr_nxt;
                  out_bit   <= lfsr_nxt[0];
                  out_valid <= 1'b1;
               end
            end
            SHIFT: begin
               if (out_valid && out_ready) begin
                  if (bitcnt == BW'(WIDTH-1)) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_bit   <= 1'b0;
                     done      <= 1'b1;
                     bitcnt    <= '0;
                  end else begin
                     snap    <= snap >> 1;
                     out_bit <= snap[1];
                     bitcnt  <= bitcnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_frame_gen.sv
// Scoreboard bench for lfsr_frame_gen at WIDTH=4, TAPS=4'h2 (x^4+x+1).
module tb_lfsr_frame_gen;

   localparam int             W  = 4;
   localparam logic [W-1:0]   TP = 4'h2;
   localparam int             CW = 16;

   logic          clk;
   logic          rst;
   logic          load;
   logic [W-1:0]  seed;
   logic          start;
   logic [CW-1:0] step_cnt;
   logic          out_ready;
   logic          out_bit;
   logic          out_valid;
   logic          busy;
   logic          done;
   logic [W-1:0]  lfsr_q;

   lfsr_frame_gen #(
      .WIDTH(W), .TAPS(TP), .CNT_W(CW), .RESET_SEED(4'h1)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .seed(seed), .start(start),
      .step_cnt(step_cnt), .out_ready(out_ready), .out_bit(out_bit),
      .out_valid(out_valid), .busy(busy), .done(done), .lfsr_q(lfsr_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           nvec = 0;
   int           nerr = 0;
   int           nxfer = 0;
   int           ndone = 0;
   bit           zero_seen = 1'b0;
   bit           hold_pend = 1'b0;
   logic         hold_bit = 1'b0;
   logic         exp_q[$];
   logic [W-1:0] model;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference step written as shift-and-mask rather than per-stage XOR.
   function automatic logic [W-1:0] ref_step(input logic [W-1:0] v);
      logic         fb;
      logic [W-1:0] sh;
`ifdef LFSR_DEBRUIJN_EN
      fb = v[W-1] ^ (v[W-2:0] == '0);
`else
      fb = v[W-1];
`endif
      sh = v << 1;
      return sh ^ (fb ? {TP[W-1:1], 1'b1} : {W{1'b0}});
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_bit", 32'(out_bit), 32'(hold_bit));
         end
         hold_pend = out_valid && !out_ready;
         hold_bit  = out_bit;
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) check("serial_bit", 32'(out_bit), 32'(exp_q.pop_front()));
            nxfer++;
         end
         if (done) ndone++;
         if (busy && lfsr_q == '0) zero_seen = 1'b1;
      end
   end

   task automatic do_load(input logic [W-1:0] s);
      seed = s;
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
`ifdef LFSR_DEBRUIJN_EN
      model = s;
`else
      model = (s == '0) ? 4'h1 : s;
`endif
      check("load_value", 32'(lfsr_q), 32'(model));
   endtask

   task automatic run_frame(input int n, input bit bp, input bit ldb);
      logic [W-1:0] snapv;
      int           cyc;
      snapv = model;
      for (int i = 0; i < n; i++) snapv = ref_step(snapv);
      model = snapv;
      for (int i = 0; i < W; i++) exp_q.push_back(snapv[i]);
      nxfer    = 0;
      step_cnt = CW'(n);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (ldb) begin
         seed = 4'h9;
         load = 1'b1;
      end
      cyc = 0;
      while (!out_valid && cyc < n + 10) begin
         @(posedge clk); #1;
         load = 1'b0;
         cyc++;
      end
      load = 1'b0;
      check("first_valid_lat", 32'(cyc), 32'(n));
      check("busy_in_frame", 32'(busy), 32'd1);
      if (bp) begin
         @(posedge clk); #1;
         out_ready = 1'b0;
         repeat (3) @(posedge clk);
         #1 out_ready = 1'b1;
      end
      while (!done && cyc < n + 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("done_seen", 32'(done), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
      check("valid_after", 32'(out_valid), 32'd0);
      check("bits_xfer", 32'(nxfer), 32'(W));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("lfsr_end", 32'(lfsr_q), 32'(model));
      @(posedge clk); #1;
      check("done_pulse_1cyc", 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dn;
      rst = 1'b0; load = 1'b0; start = 1'b0; seed = '0; step_cnt = '0;
      out_ready = 1'b1; model = 4'h1;
      repeat (2) @(negedge clk);
      check("rst_lfsr", 32'(lfsr_q), 32'h1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(posedge clk); #3 rst = 1'b1;
      @(posedge clk); #1;

      run_frame(4, 1'b0, 1'b0);
      check("snap_4steps", 32'(lfsr_q), 32'h3);

      do_load(4'h1);
      zero_seen = 1'b0;
`ifdef LFSR_DEBRUIJN_EN
      run_frame(16, 1'b0, 1'b0);
      check("period_return", 32'(lfsr_q), 32'h1);
      check("zero_visited", 32'(zero_seen), 32'd1);
`else
      run_frame(15, 1'b0, 1'b0);
      check("period_return", 32'(lfsr_q), 32'h1);
      check("zero_visited", 32'(zero_seen), 32'd0);
`endif

      run_frame(2, 1'b1, 1'b0);

      seed = 4'h5; load = 1'b1; start = 1'b1; step_cnt = CW'(3);
      @(posedge clk); #1;
      load = 1'b0; start = 1'b0;
      model = 4'h5;
      check("ldstart_busy", 32'(busy), 32'd0);
      check("ldstart_lfsr", 32'(lfsr_q), 32'h5);
      @(posedge clk); #1;
      check("ldstart_busy2", 32'(busy), 32'd0);

      run_frame(3, 1'b0, 1'b1);

      do_load(4'h0);

      out_ready = 1'b0; step_cnt = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("n0_valid", 32'(out_valid), 32'd1);
      check("n0_bit", 32'(out_bit), 32'(model[0]));
      @(posedge clk); #1;
      dn = ndone;
      #2 rst = 1'b0;
      #1;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_lfsr", 32'(lfsr_q), 32'h1);
      check("abort_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("abort_done", 32'(done), 32'd0);
      check("abort_ndone", 32'(ndone), 32'(dn));
      #2 rst = 1'b1;
      model = 4'h1; out_ready = 1'b1;
      @(posedge clk); #1;

      run_frame(0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
